// File: rtl/fpga_cfg_pkg.sv
// ----------------------------------------------------------------------------
// fpga_cfg_pkg
// Definitions shared by the configuration readback path and the config loader.
//   - CFG_CHAIN_LEN / CFG_WORD_W : default chain length and host word width
//   - cfg_state_t and St* values : readback controller state encoding
// ----------------------------------------------------------------------------
package fpga_cfg_pkg;

   localparam int unsigned CFG_CHAIN_LEN = 1024;
   localparam int unsigned CFG_WORD_W    = 32;

   typedef logic [1:0] cfg_state_t;

   localparam cfg_state_t StIdle  = 2'd0;
   localparam cfg_state_t StShift = 2'd1;
   localparam cfg_state_t StDrain = 2'd2;
   localparam cfg_state_t StDone  = 2'd3;

endpackage

// File: rtl/fpga_cfg_deser.sv
// ----------------------------------------------------------------------------
// fpga_cfg_deser
// Serial-to-parallel packer for the config readback stream, LSB first.
// Ports:
//   clk_i, rstn_i  clock, async active-low reset
//   clear_i        return to the start of a word (held while the controller idles)
//   sample_i       bit_i is captured on this edge
//   bit_i          serial bit from the chain tail
//   last_i         the bit at the current position is the final chain bit
//   will_done_o    the next captured bit completes a word (independent of sample_i)
//   word_done_o    a word completes on this edge
//   word_o         completed word including bit_i, unused upper bits zeroed
// ----------------------------------------------------------------------------
module fpga_cfg_deser #(
   parameter int unsigned WORD_W = 32
) (
   input  logic              clk_i,
   input  logic              rstn_i,
   input  logic              clear_i,
   input  logic              sample_i,
   input  logic              bit_i,
   input  logic              last_i,
   output logic              will_done_o,
   output logic              word_done_o,
   output logic [WORD_W-1:0] word_o
);

   localparam int unsigned IDX_W = $clog2(WORD_W);

   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [WORD_W-1:0] sreg_q, sreg_d;

   // Must not depend on sample_i: the top level derives the shift enable from it.
   assign will_done_o = (idx_q == IDX_W'(WORD_W - 1)) || last_i;
   assign word_done_o = sample_i && will_done_o;

   // Bits at or above the current index are padding, except the incoming bit.
   always_comb begin
      word_o = '0;
      for (int i = 0; i < int'(WORD_W); i++) begin
         if (IDX_W'(i) < idx_q) begin
            word_o[i] = sreg_q[i];
         end else if (IDX_W'(i) == idx_q) begin
            word_o[i] = bit_i;
         end
      end
   end

   always_comb begin
      sreg_d = sreg_q;
      idx_d  = idx_q;
      if (clear_i) begin
         sreg_d = '0;
         idx_d  = '0;
      end else if (sample_i) begin
         if (will_done_o) begin
            sreg_d = '0;
            idx_d  = '0;
         end else begin
            sreg_d[idx_q] = bit_i;
            idx_d         = idx_q + IDX_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         sreg_q <= '0;
         idx_q  <= '0;
      end else begin
         sreg_q <= sreg_d;
         idx_q  <= idx_d;
      end
   end

endmodule

// File: rtl/fpga_cfg_readback.sv
// ----------------------------------------------------------------------------
// fpga_cfg_readback
// Non-destructive readback of the configuration shift chain. The tail bit is
// sampled and recirculated into the head, so after CHAIN_LEN shifts the chain
// holds its original contents. Bits are packed into WORD_W words and streamed
// to the host over valid/ready.
// Ports:
//   clk_i, rstn_i                  config clock, async active-low reset
//   start_i                        begin a readback (ignored while busy)
//   busy_o, done_o                 status; done_o is a one-cycle pulse
//   chain_shift_o                  chain shift enable
//   chain_data_o / chain_data_i    chain head input / chain tail output
//   rd_data_o, rd_valid_o,
//   rd_ready_i, rd_last_o          host word stream
// ----------------------------------------------------------------------------
module fpga_cfg_readback
   import fpga_cfg_pkg::*;
#(
   parameter int unsigned CHAIN_LEN = CFG_CHAIN_LEN,
   parameter int unsigned WORD_W    = CFG_WORD_W
) (
   input  logic              clk_i,
   input  logic              rstn_i,
   input  logic              start_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              chain_shift_o,
   output logic              chain_data_o,
   input  logic              chain_data_i,
   output logic [WORD_W-1:0] rd_data_o,
   output logic              rd_valid_o,
   input  logic              rd_ready_i,
   output logic              rd_last_o
);

   localparam int unsigned CNT_W = $clog2(CHAIN_LEN + 1);

   cfg_state_t        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              valid_q, valid_d;
   logic              last_q, last_d;
   logic [WORD_W-1:0] data_q, data_d;

   logic              last_bit;
   logic              will_done;
   logic              word_done;
   logic [WORD_W-1:0] word;

   assign last_bit = (cnt_q == CNT_W'(CHAIN_LEN - 1));

   // Stall only if the next bit would complete a word while the output register
   // is still occupied; rd_ready_i frees it in the same cycle.
   assign chain_shift_o = (state_q == StShift) && !(will_done && valid_q && !rd_ready_i);
   assign chain_data_o  = chain_shift_o & chain_data_i;

   fpga_cfg_deser #(
      .WORD_W(WORD_W)
   ) u_deser (
      .clk_i      (clk_i),
      .rstn_i     (rstn_i),
      .clear_i    (state_q == StIdle),
      .sample_i   (chain_shift_o),
      .bit_i      (chain_data_i),
      .last_i     (last_bit),
      .will_done_o(will_done),
      .word_done_o(word_done),
      .word_o     (word)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (state_q == StIdle) begin
         cnt_d = '0;
      end else if (chain_shift_o) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
      case (state_q)
         StIdle:  if (start_i) state_d = StShift;
         StShift: if (chain_shift_o && last_bit) state_d = StDrain;
         StDrain: if (valid_q && rd_ready_i) state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // The stall guarantees word_done never coincides with an unaccepted word.
   always_comb begin
      valid_d = valid_q;
      last_d  = last_q;
      data_d  = data_q;
      if (word_done) begin
         valid_d = 1'b1;
         last_d  = last_bit;
         data_d  = word;
      end else if (valid_q && rd_ready_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         last_q  <= last_d;
         data_q  <= data_d;
      end
   end

   assign busy_o     = (state_q != StIdle);
   assign done_o     = (state_q == StDone);
   assign rd_data_o  = data_q;
   assign rd_valid_o = valid_q;
   assign rd_last_o  = valid_q & last_q;

endmodule
